businv_codec: RTL and testbench



---
 rtl/businv_pkg.sv | 29 ++
 rtl/bi_segment.sv | 48 ++++
 rtl/businv_codec.sv | 201 ++++++++++++++++++++
 tb/tb_businv_codec.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/businv_pkg.sv
// businv_pkg
// Shared definitions for the bus-invert / T0 low-power bus codec.
//   mode_e    : run-time encoding mode carried with every accepted word
//   popcount  : ones count of a vector of up to POP_MAX_W bits
//               (callers zero-extend their operand to POP_MAX_W)
package businv_pkg;

    typedef enum logic [1:0] {
        MODE_RAW  = 2'b00,
        MODE_BI   = 2'b01,
        MODE_T0   = 2'b10,
        MODE_T0BI = 2'b11
    } mode_e;

    // Widest vector popcount accepts, and the width of its result.
    // W+P+1 (all bus lines) must not exceed POP_MAX_W.
    localparam int POP_MAX_W = 256;
    localparam int POP_CNT_W = 9;

    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [POP_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + POP_CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/bi_segment.sv
// bi_segment
// Bus-invert decision for one S-bit segment of the bus. Purely combinational.
// It weighs the number of line toggles of sending the word as-is against
// sending it inverted, counting the segment's own invert line in both costs.
//   din_seg   in  S  segment of the source word
//   bus_seg   in  S  segment value currently on the bus
//   inv_prev  in  1  segment invert line currently on the bus
//   bus_next  out S  segment value to drive next
//   inv_next  out 1  invert line to drive next
module bi_segment
    import businv_pkg::*;
#(
    parameter int S = 8
) (
    input  logic [S-1:0] din_seg,
    input  logic [S-1:0] bus_seg,
    input  logic         inv_prev,
    output logic [S-1:0] bus_next,
    output logic         inv_next
);

    // Costs never exceed S+1, so CW bits are enough.
    localparam int CW = $clog2(S + 2);

    logic [CW-1:0] ham;
    logic [CW-1:0] cost_n;
    logic [CW-1:0] cost_i;
    logic          invert;

    always_comb begin
        ham    = CW'(popcount(POP_MAX_W'(din_seg ^ bus_seg)));
        // Sending plain toggles the data lines that differ and drops inv if set;
        // sending inverted toggles the rest and raises inv if clear.
        cost_n = ham + CW'(inv_prev);
        cost_i = CW'(S) - ham + CW'(!inv_prev);
        if (cost_i < cost_n) begin
            invert = 1'b1;
        end else if (cost_n < cost_i) begin
            invert = 1'b0;
        end else begin
            // Equal cost: leave the invert line where it is.
            invert = inv_prev;
        end
        bus_next = invert ? ~din_seg : din_seg;
        inv_next = invert;
    end

endmodule

// File: rtl/businv_codec.sv
// businv_codec
// Low-power bus encoder plus registered decoder and transition counter.
// Encoder modes (sampled with each accepted word): raw, partitioned
// bus-invert, T0 (sequential words signalled on INC, bus frozen), and T0 with
// bus-invert for non-sequential words.
//   ck           in   1     clock, rising edge
//   rst          in   1     asynchronous active-low reset
//   mode         in   2     encoding mode for the word on din
//   din          in   W     source word
//   din_valid    in   1     accept din at this edge
//   cnt_clr      in   1     synchronous clear of trans_count (wins over count)
//   bus          out  W     encoded data lines (registered, latency 1)
//   inv          out  P     per-segment invert lines (registered)
//   inc          out  1     T0 increment line (registered)
//   dout         out  W     decoded word (latency 2)
//   dout_valid   out  1     dout strobe
//   trans_count  out  CNTW  saturating count of bus/inv/inc line toggles
module businv_codec
    import businv_pkg::*;
#(
    parameter int W      = 8,
    parameter int P      = 1,
    parameter int STRIDE = 1,
    parameter int CNTW   = 16
) (
    input  logic            ck,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic [W-1:0]    din,
    input  logic            din_valid,
    input  logic            cnt_clr,
    output logic [W-1:0]    bus,
    output logic [P-1:0]    inv,
    output logic            inc,
    output logic [W-1:0]    dout,
    output logic            dout_valid,
    output logic [CNTW-1:0] trans_count
);

    localparam int S    = W / P;
    localparam int LW   = W + P + 1;
    localparam int SUMW = ((CNTW > POP_CNT_W) ? CNTW : POP_CNT_W) + 1;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    // Encoder state
    logic [W-1:0]    bus_q, bus_d;
    logic [P-1:0]    inv_q, inv_d;
    logic            inc_q, inc_d;
    logic [W-1:0]    prev_din_q, prev_din_d;
    logic            first_q, first_d;
    // Side-band travelling with the encoded word to the decoder
    mode_e           dec_mode_q, dec_mode_d;
    logic            enc_valid_q, enc_valid_d;
    // Decoder state
    logic [W-1:0]    dout_q, dout_d;
    logic            dout_valid_q, dout_valid_d;
    // Activity counter
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Bus-invert candidate for every segment, computed against the live bus
    logic [W-1:0]    bi_bus;
    logic [P-1:0]    bi_inv;
    // Invert lines stretched to cover their segment, for decoding
    logic [W-1:0]    inv_exp;

    logic            seq_hit;
    logic [LW-1:0]   lines_q, lines_d;
    logic [POP_CNT_W-1:0] toggles;
    logic [SUMW-1:0] cnt_sum;

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_seg
            bi_segment #(
                .S(S)
            ) u_bi_segment (
                .din_seg  (din[gi*S +: S]),
                .bus_seg  (bus_q[gi*S +: S]),
                .inv_prev (inv_q[gi]),
                .bus_next (bi_bus[gi*S +: S]),
                .inv_next (bi_inv[gi])
            );
            assign inv_exp[gi*S +: S] = {S{inv_q[gi]}};
        end
    endgenerate

    // Encoder next state
    always_comb begin
        // Sequential only once a previous word exists; the add wraps mod 2^W.
        seq_hit     = !first_q && (din == prev_din_q + W'(STRIDE));
        bus_d       = bus_q;
        inv_d       = inv_q;
        inc_d       = inc_q;
        prev_din_d  = prev_din_q;
        first_d     = first_q;
        dec_mode_d  = dec_mode_q;
        enc_valid_d = din_valid;
        if (din_valid) begin
            prev_din_d = din;
            first_d    = 1'b0;
            dec_mode_d = mode_e'(mode);
            case (mode_e'(mode))
                MODE_RAW: begin
                    bus_d = din;
                    inv_d = '0;
                    inc_d = 1'b0;
                end
                MODE_BI: begin
                    bus_d = bi_bus;
                    inv_d = bi_inv;
                    inc_d = 1'b0;
                end
                MODE_T0: begin
                    if (seq_hit) begin
                        // bus and inv stay frozen; only INC signals the word
                        inc_d = 1'b1;
                    end else begin
                        bus_d = din;
                        inv_d = '0;
                        inc_d = 1'b0;
                    end
                end
                MODE_T0BI: begin
                    if (seq_hit) begin
                        inc_d = 1'b1;
                    end else begin
                        bus_d = bi_bus;
                        inv_d = bi_inv;
                        inc_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // Decoder next state: works only from what is on the bus plus the mode
    // that travelled with the word, so it models a real far-end receiver.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = enc_valid_q;
        if (enc_valid_q) begin
            if (inc_q && (dec_mode_q == MODE_T0 || dec_mode_q == MODE_T0BI)) begin
                dout_d = dout_q + W'(STRIDE);
            end else begin
                dout_d = bus_q ^ inv_exp;
            end
        end
    end

    // Transition counter: toggles across every driven line, old vs new
    always_comb begin
        lines_q = {bus_q, inv_q, inc_q};
        lines_d = {bus_d, inv_d, inc_d};
        toggles = popcount(POP_MAX_W'(lines_d ^ lines_q));
        cnt_sum = SUMW'(cnt_q) + SUMW'(toggles);
        cnt_d   = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (din_valid) begin
            if (cnt_sum > SUMW'(CNT_MAX)) begin
                cnt_d = CNT_MAX;
            end else begin
                cnt_d = cnt_sum[CNTW-1:0];
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            bus_q        <= '0;
            inv_q        <= '0;
            inc_q        <= 1'b0;
            prev_din_q   <= '0;
            first_q      <= 1'b1;
            dec_mode_q   <= MODE_RAW;
            enc_valid_q  <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            bus_q        <= bus_d;
            inv_q        <= inv_d;
            inc_q        <= inc_d;
            prev_din_q   <= prev_din_d;
            first_q      <= first_d;
            dec_mode_q   <= dec_mode_d;
            enc_valid_q  <= enc_valid_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus         = bus_q;
    assign inv         = inv_q;
    assign inc         = inc_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign trans_count = cnt_q;

endmodule

// File: tb/tb_businv_codec.sv
// tb_businv_codec
// Two codec instances share one stimulus stream: dut_a (W=8, P=1, CNTW=16)
// and dut_b (W=8, P=2, CNTW=4). Encoder outputs are compared row by row
// against a hand-computed table; decoded words are compared by a scoreboard
// that queues every accepted word and pops it when dout_valid appears.
module tb_businv_codec;

    logic        ck;
    logic        rst;
    logic [1:0]  mode;
    logic [7:0]  din;
    logic        din_valid;
    logic        cnt_clr;

    logic [7:0]  bus_a, dout_a;
    logic [0:0]  inv_a;
    logic        inc_a, dv_a;
    logic [15:0] cnt_a;

    logic [7:0]  bus_b, dout_b;
    logic [1:0]  inv_b;
    logic        inc_b, dv_b;
    logic [3:0]  cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    businv_codec #(.W(8), .P(1), .STRIDE(1), .CNTW(16)) dut_a (
        .ck(ck), .rst(rst), .mode(mode), .din(din), .din_valid(din_valid),
        .cnt_clr(cnt_clr), .bus(bus_a), .inv(inv_a), .inc(inc_a),
        .dout(dout_a), .dout_valid(dv_a), .trans_count(cnt_a)
    );

    businv_codec #(.W(8), .P(2), .STRIDE(1), .CNTW(4)) dut_b (
        .ck(ck), .rst(rst), .mode(mode), .din(din), .din_valid(din_valid),
        .cnt_clr(cnt_clr), .bus(bus_b), .inv(inv_b), .inc(inc_b),
        .dout(dout_b), .dout_valid(dv_b), .trans_count(cnt_b)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: decoded words must come out in order, one per accepted word.
    always @(negedge ck) begin
        if (rst && dv_a) begin
            n_checks++;
            if (qa.size() == 0) begin
                $display("FAIL dout_a_unexpected: got 0x%0h, expected no word", dout_a);
            end else begin
                logic [7:0] e;
                e = qa.pop_front();
                if (dout_a !== e) $display("FAIL dout_a: got 0x%0h, expected 0x%0h", dout_a, e);
                else n_pass++;
            end
        end
        if (rst && dv_b) begin
            n_checks++;
            if (qb.size() == 0) begin
                $display("FAIL dout_b_unexpected: got 0x%0h, expected no word", dout_b);
            end else begin
                logic [7:0] e;
                e = qb.pop_front();
                if (dout_b !== e) $display("FAIL dout_b: got 0x%0h, expected 0x%0h", dout_b, e);
                else n_pass++;
            end
        end
    end

    // Present one input set for one clock edge; returns 1 time unit after it.
    task automatic drive(input logic [1:0] md, input logic [7:0] d, input logic v, input logic c);
        mode      = md;
        din       = d;
        din_valid = v;
        cnt_clr   = c;
        if (v) begin
            qa.push_back(d);
            qb.push_back(d);
        end
        @(posedge ck);
        #1;
        din_valid = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_enc_a"}, 32'({bus_a, inv_a, inc_a}), 32'd0);
        chk({tag, "_dec_a"}, 32'({dout_a, dv_a}), 32'd0);
        chk({tag, "_cnt_a"}, 32'(cnt_a), 32'd0);
        chk({tag, "_enc_b"}, 32'({bus_b, inv_b, inc_b}), 32'd0);
        chk({tag, "_dec_b"}, 32'({dout_b, dv_b}), 32'd0);
        chk({tag, "_cnt_b"}, 32'(cnt_b), 32'd0);
    endtask

    typedef struct packed {
        logic [1:0]  md;
        logic [7:0]  d;
        logic        v;
        logic        c;
        logic [7:0]  e_bus;
        logic        e_inv;
        logic        e_inc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           mode   din    v     c     bus    inv   inc   count (dut_a)
        tbl[0]  = '{2'b01, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{2'b01, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'd1};
        tbl[2]  = '{2'b01, 8'h0F, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 16'd5};
        tbl[3]  = '{2'b01, 8'hF0, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 16'd6};
        tbl[4]  = '{2'b00, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 16'd10};
        tbl[5]  = '{2'b10, 8'h10, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 16'd13};
        tbl[6]  = '{2'b10, 8'h11, 1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 16'd14};
        tbl[7]  = '{2'b10, 8'h12, 1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 16'd14};
        tbl[8]  = '{2'b10, 8'hAA, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 16'd14};
        tbl[9]  = '{2'b01, 8'h55, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 16'd14};
        tbl[10] = '{2'b11, 8'hAA, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 16'd14};
        tbl[11] = '{2'b10, 8'h13, 1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 16'd14};
        tbl[12] = '{2'b10, 8'h40, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 16'd17};
        tbl[13] = '{2'b11, 8'h41, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1, 16'd18};
        tbl[14] = '{2'b11, 8'hBF, 1'b1, 1'b0, 8'h40, 1'b1, 1'b0, 16'd20};
        tbl[15] = '{2'b11, 8'hC0, 1'b1, 1'b0, 8'h40, 1'b1, 1'b1, 16'd21};
        tbl[16] = '{2'b11, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd24};
        tbl[17] = '{2'b01, 8'h1F, 1'b1, 1'b1, 8'hE0, 1'b1, 1'b0, 16'd0};
        tbl[18] = '{2'b00, 8'hE0, 1'b1, 1'b0, 8'hE0, 1'b0, 1'b0, 16'd1};
        tbl[19] = '{2'b00, 8'h77, 1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, 16'd0};

        mode = 2'b00; din = 8'h00; din_valid = 1'b0; cnt_clr = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge ck);
        rst = 1'b1;

        // Table: all four modes, idle gap inside a T0 run, clear-wins
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].md, tbl[i].d, tbl[i].v, tbl[i].c);
            $display("row %0d mode=%b din=%h v=%b clr=%b -> bus=%h inv=%b inc=%b cnt=%0d dv=%b",
                     i, tbl[i].md, tbl[i].d, tbl[i].v, tbl[i].c, bus_a, inv_a, inc_a, cnt_a, dv_a);
            chk($sformatf("row%0d_bus", i), 32'(bus_a), 32'(tbl[i].e_bus));
            chk($sformatf("row%0d_inv", i), 32'(inv_a), 32'(tbl[i].e_inv));
            chk($sformatf("row%0d_inc", i), 32'(inc_a), 32'(tbl[i].e_inc));
            chk($sformatf("row%0d_cnt", i), 32'(cnt_a), 32'(tbl[i].e_cnt));
        end
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        chk("drain1_a", 32'(qa.size()), 32'd0);
        chk("drain1_b", 32'(qb.size()), 32'd0);

        // Fresh start for the two-partition instance
        rst = 1'b0;
        #1 chk_all_zero("reset2");
        qa.delete(); qb.delete();
        @(negedge ck);
        rst = 1'b1;

        drive(2'b01, 8'h00, 1'b1, 1'b0);
        $display("p2 din=00 -> bus=%h inv=%b cnt=%0d", bus_b, inv_b, cnt_b);
        chk("p2_bus0", 32'(bus_b), 32'h00);
        chk("p2_inv0", 32'(inv_b), 32'h0);
        drive(2'b01, 8'hF1, 1'b1, 1'b0);
        $display("p2 din=F1 -> bus=%h inv=%b cnt=%0d", bus_b, inv_b, cnt_b);
        chk("p2_bus1", 32'(bus_b), 32'h01);
        chk("p2_inv1", 32'(inv_b), 32'h2);
        chk("p2_cnt1", 32'(cnt_b), 32'd2);

        // Saturation of the 4-bit counter, then clear together with a word
        begin
            logic [7:0] sat_d [5];
            logic [3:0] sat_e [5];
            sat_d[0] = 8'h0F; sat_e[0] = 4'd6;
            sat_d[1] = 8'h00; sat_e[1] = 4'd10;
            sat_d[2] = 8'h0F; sat_e[2] = 4'd14;
            sat_d[3] = 8'h00; sat_e[3] = 4'd15;
            sat_d[4] = 8'h0F; sat_e[4] = 4'd15;
            for (int i = 0; i < 5; i++) begin
                drive(2'b00, sat_d[i], 1'b1, 1'b0);
                $display("sat din=%h -> bus=%h cnt=%0d", sat_d[i], bus_b, cnt_b);
                chk($sformatf("sat%0d_cnt", i), 32'(cnt_b), 32'(sat_e[i]));
            end
        end
        drive(2'b00, 8'h00, 1'b1, 1'b1);
        $display("clr din=00 -> bus=%h cnt=%0d", bus_b, cnt_b);
        chk("clr_cnt", 32'(cnt_b), 32'd0);
        chk("clr_bus", 32'(bus_b), 32'h00);

        // Reset between edges with a word in flight and another on the inputs
        drive(2'b10, 8'h55, 1'b1, 1'b0);
        mode = 2'b10; din = 8'h56; din_valid = 1'b1;
        #2 rst = 1'b0;
        #1 chk_all_zero("midrst");
        qa.delete(); qb.delete();
        din_valid = 1'b0;
        @(negedge ck);
        rst = 1'b1;

        // First word after reset must not be treated as sequential
        drive(2'b10, 8'h01, 1'b1, 1'b0);
        $display("post-reset din=01 -> bus=%h inc=%b", bus_a, inc_a);
        chk("post_inc_a", 32'(inc_a), 32'd0);
        chk("post_bus_a", 32'(bus_a), 32'h01);
        chk("post_inc_b", 32'(inc_b), 32'd0);
        drive(2'b10, 8'h02, 1'b1, 1'b0);
        $display("post-reset din=02 -> bus=%h inc=%b", bus_a, inc_a);
        chk("post2_inc_a", 32'(inc_a), 32'd1);
        chk("post2_bus_a", 32'(bus_a), 32'h01);
        chk("post2_inc_b", 32'(inc_b), 32'd1);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0);
        chk("drain2_a", 32'(qa.size()), 32'd0);
        chk("drain2_b", 32'(qb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
